// File: rtl/pts_pkg.sv
// Shared types and constants for the pts_serializer two-wire framer.
// Holds the frame state encoding, parity modes and a frame-length helper.
package pts_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      BIT_LO,
      BIT_HI,
      STOP_LO,
      STOP_HI
   } state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Number of serial bits in a frame: the data word plus an optional parity bit.
   function automatic int frame_len(input int width, input int parity);
      return width + ((parity != PAR_NONE) ? 1 : 0);
   endfunction

endpackage

// File: rtl/pts_phase_timer.sv
// Half-period down-counter: phase_end is high in the last cycle of a HALF-cycle
// phase. Reloading on every state change means the count never wraps inside a state.
module pts_phase_timer #(
   parameter int HALF = 1
) (
   input  logic sclk,
   input  logic rst,
   input  logic load,
   output logic phase_end
);

   localparam int CW = $clog2(HALF + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge sclk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(HALF - 1);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign phase_end = (cnt == '0);

endmodule

// File: rtl/pts_serializer.sv
// Parallel-to-serial framer driving scl/sda: start condition, data bits with an
// optional parity bit, stop condition. Every output is registered from the next state.
module pts_serializer
   import pts_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int HALF      = 1,
   parameter int MSB_FIRST = 1,
   parameter int PARITY    = 0
) (
   input  logic             sclk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data,
   input  logic             valid,
   output logic             ack,
   output logic             scl,
   output logic             sda,
   output logic             busy,
   output logic             done
);

   localparam int N  = frame_len(WIDTH, PARITY);
   localparam int BW = $clog2(N + 1);

   state_t          state, state_n;
   logic            phase_end;
   logic            accept;
   logic            enter_bit;
   logic            scl_n, sda_n;
   logic [N-1:0]    frame;
   logic [N-1:0]    sr;
   logic [BW-1:0]   bits_left;

   pts_phase_timer #(.HALF(HALF)) u_timer (
      .sclk      (sclk),
      .rst       (rst),
      .load      (state_n != state),
      .phase_end (phase_end)
   );

   assign accept    = valid && ack;
   assign enter_bit = (state_n == BIT_LO) && (state != BIT_LO);

   // Frame laid out in transmit order: element N-1 goes on the wire first.
   always_comb begin
      frame = '0;
      for (int i = 0; i < WIDTH; i++) begin
         frame[N-1-i] = (MSB_FIRST != 0) ? data[WIDTH-1-i] : data[i];
      end
      if (PARITY != PAR_NONE) begin
         frame[0] = (PARITY == PAR_ODD) ? ~(^data) : ^data;
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (accept)    state_n = START;
         START:   if (phase_end) state_n = BIT_LO;
         BIT_LO:  if (phase_end) state_n = BIT_HI;
         BIT_HI:  if (phase_end) state_n = (bits_left != '0) ? BIT_LO : STOP_LO;
         STOP_LO: if (phase_end) state_n = STOP_HI;
         STOP_HI: if (phase_end) state_n = IDLE;
         default:                state_n = IDLE;
      endcase
   end

   always_comb begin
      scl_n = 1'b1;
      sda_n = sda;
      unique case (state_n)
         IDLE:    sda_n = 1'b1;
         START:   sda_n = 1'b0;
         BIT_LO: begin
            scl_n = 1'b0;
            if (state != BIT_LO) sda_n = sr[N-1];
         end
         BIT_HI:  sda_n = sda;
         STOP_LO: begin
            scl_n = 1'b0;
            sda_n = 1'b0;
         end
         STOP_HI: sda_n = 1'b0;
         default: sda_n = 1'b1;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         state     <= IDLE;
         scl       <= 1'b1;
         sda       <= 1'b1;
         ack       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bits_left <= '0;
      end else begin
         state <= state_n;
         scl   <= scl_n;
         sda   <= sda_n;
         ack   <= (state_n == IDLE);
         busy  <= (state_n != IDLE);
         done  <= (state == STOP_HI) && (state_n == IDLE);
         if (accept) begin
            bits_left <= BW'(N);
         end else if (enter_bit) begin
            bits_left <= bits_left - BW'(1);
         end
      end
   end

   // NOTE: the shift register carries no reset; it is always loaded on acceptance
   // before any of its bits can reach sda.
   always_ff @(posedge sclk) begin
      if (accept) begin
         sr <= frame;
      end else if (enter_bit) begin
         sr <= sr << 1;
      end
   end

endmodule
